sdcmd_responder: RTL
====================

# sdcmd_responder

Card-side CMD-line engine for the SD/eMMC subsystem: the device end of the command protocol that the host controller initiates. Samples 48-bit host commands on the CMD line, checks framing and CRC7, and presents each valid command to device logic. Accepts a response (none, 48-bit, 48-bit without CRC, or 136-bit R2) and serializes it back onto CMD after the Ncr gap. Used as the card model in bench/Verilator builds and as the front half of a synthesizable card emulator.

## Interface
- NCR, 2: minimum SDCLK periods between the command end bit and the response start bit (≥2).
- NCR_MAX, 64: SDCLK periods allowed in WAIT before the pending command is dropped; NCR_MAX > NCR.
- i_clk  input  1  system clock; the only clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_ck_en  input  1  one-cycle strobe marking each SDCLK rising edge; all bit-level activity happens only on strobe cycles.
- i_cmd  input  1  CMD line level as seen by the card.
- o_cmd_oe  output  1  high while the card drives CMD.
- o_cmd  output  1  driven CMD level; 1 whenever o_cmd_oe is 0.
- o_req_valid  output  1  one-cycle pulse: a valid command was received.
- o_req_index  output  6  command index; held until the next valid command.
- o_req_arg  output  32  command argument; held like o_req_index.
- o_rx_err  output  1  one-cycle pulse on bad CRC7 or bad end bit.
- i_rsp_valid  input  1  response offered.
- o_rsp_ready  output  1  high only in WAIT.
- i_rsp_kind  input  2  00 none, 01 short with CRC, 10 long R2, 11 short without CRC (R3).
- i_rsp_index  input  6  index field for short responses.
- i_rsp_arg  input  32  argument field for short responses.
- i_rsp_long  input  120  R2 payload (CID/CSD bits 127:8), MSB first.
- o_rsp_timeout  output  1  one-cycle pulse when WAIT expires.
- o_busy  output  1  state ≠ IDLE.

## Operation
- CRC7 uses x^7+x^3+1 with initial value 0, computed MSB first. A short frame's CRC covers its first 40 bits; an R2 frame's CRC covers only the 120 payload bits.
- IDLE: on a strobe where i_cmd=0 (start bit), clear the bit counter and CRC, then go to RX.
- RX: shift in 47 more bits on strobes. Bit 46 is the transmission bit; bits 45:40 are the index; bits 39:8 are the argument; bits 7:1 are the CRC; bit 0 is the end bit.
- CHECK (one i_clk cycle after the end-bit strobe):
  - Transmission bit 0: the frame is not from the host. Return to IDLE silently with no pulses.
  - Otherwise, if CRC mismatches or end bit=0: pulse o_rx_err and return to IDLE.
  - Otherwise: update o_req_index/arg, pulse o_req_valid, go to WAIT with the period counter at 0.
- WAIT: the counter increments on each strobe. A response is accepted on any i_clk cycle with i_rsp_valid&&o_rsp_ready.
  - kind 00: return to IDLE.
  - Other kinds: load the TX shift register, then go to TX.
  - Counter reaching NCR_MAX with no handshake: pulse o_rsp_timeout and go to IDLE.
- TX frame formats:
  - Short: 0, 0, index[5:0], arg[31:0], crc7, 1 (48 bits).
  - R3: 0, 0, 111111, arg, 1111111, 1. R3 ignores i_rsp_index.
  - R2: 0, 0, 111111, payload[119:0], crc7, 1 (136 bits).
- TX drive sequence:
  - The start bit is driven at the first strobe where the counter ≥ NCR and the response is loaded.
  - Each following strobe presents the next bit.
  - The strobe after the end bit drops o_cmd_oe and returns to IDLE.
- i_cmd is ignored outside IDLE and RX. A 0 sampled during TX is not a start bit.

## Timing
- Reset values: o_cmd_oe=0, o_cmd=1, o_req_valid=0, o_req_index=0, o_req_arg=0, o_rx_err=0, o_rsp_ready=0, o_rsp_timeout=0, o_busy=0, state IDLE. Reset asserted mid-RX or mid-TX releases CMD immediately.
- o_req_valid/o_rx_err: exactly one i_clk after the end-bit strobe.
- o_rsp_ready rises together with o_req_valid and falls the cycle after the handshake or timeout.
- With the response accepted in the o_req_valid cycle, the start bit appears on the NCR-th strobe after the end-bit strobe, i.e. Ncr = NCR periods.
- A late response (counter already ≥ NCR) starts on the next strobe.
- o_cmd/o_cmd_oe are registered, changing only on strobe cycles. A strobe on every i_clk cycle is legal.
- Simultaneous handshake and NCR_MAX expiry: the handshake wins.

## Test plan
- Reset values: hold i_reset_n=0 mid-TX → o_cmd_oe=0 and o_cmd=1 immediately; all outputs at their reset values.
- CMD0: send frame 0x40_00000000_95 → o_req_valid pulse, index 0x00, arg 0x00000000; o_rsp_ready=1.
- CMD8: send 0x48_000001AA_87 → index 8, arg 0x1AA. Flip one arg bit → o_rx_err, no o_req_valid.
- Short response with CRC: respond kind 01, index 0, arg 0 with NCR=2 → the 48 bits 0x000000000001 appear on CMD starting at the 2nd strobe after the end bit; o_cmd_oe high for exactly 48 strobes.
- R3: respond kind 11, arg 0x80FF8000 → CMD carries 0x3F80FF8000FF.
- R2 and timeout:
  - kind 10, payload 0 → 136 bits: 0x3F, 15 zero bytes, then 0x01.
  - No response offered → o_rsp_timeout at strobe NCR_MAX, then back in IDLE.
  - Host frame with transmission bit 0 → no pulses at all.

Source files
------------

// File: rtl/sdcmd_responder.sv
// Card-side SD/eMMC CMD-line engine: receives 48-bit host commands, checks CRC7 and framing,
// hands valid commands to device logic and serializes the chosen response after the Ncr gap.
module sdcmd_responder #(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ck_en,
    input  logic          i_cmd,
    output logic          o_cmd_oe,
    output logic          o_cmd,
    output logic          o_req_valid,
    output logic [5:0]    o_req_index,
    output logic [31:0]   o_req_arg,
    output logic          o_rx_err,
    input  logic          i_rsp_valid,
    output logic          o_rsp_ready,
    input  logic [1:0]    i_rsp_kind,
    input  logic [5:0]    i_rsp_index,
    input  logic [31:0]   i_rsp_arg,
    input  logic [119:0]  i_rsp_long,
    output logic          o_rsp_timeout,
    output logic          o_busy
);
    localparam int            CW        = $clog2(NCR_MAX + 1);
    localparam logic [CW-1:0] NCR_C     = CW'(NCR);
    localparam logic [CW-1:0] NCR_MAX_C = CW'(NCR_MAX);

    typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [6:0] crc7_120(input logic [119:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_t         state, state_nxt;
    logic [45:0]    rx_sr;
    logic [5:0]     rx_cnt;
    logic [CW-1:0]  wcnt;
    logic [135:0]   tx_sr;
    logic [7:0]     tx_left;
    logic           tx_on;

    logic [46:0]    rx_frame;
    logic           rx_done, rx_good;
    logic [CW-1:0]  wcnt_inc;
    logic           handshake, expire, tx_drive, tx_done;
    logic [135:0]   tx_frame;

    // The check happens on the end-bit strobe itself so the result is registered
    // and visible exactly one cycle later, together with WAIT/ready.
    assign rx_frame  = {rx_sr, i_cmd};
    assign rx_done   = (state == RX) && i_ck_en && (rx_cnt == 6'd46);
    assign rx_good   = rx_frame[0] && (rx_frame[7:1] == crc7_40({1'b0, rx_frame[46:8]}));
    assign wcnt_inc  = (wcnt == NCR_MAX_C) ? wcnt : wcnt + 1'b1;
    assign handshake = (state == WAIT) && i_rsp_valid;
    assign expire    = (state == WAIT) && i_ck_en && !i_rsp_valid && (wcnt_inc == NCR_MAX_C);
    assign tx_drive  = (state == TX) && i_ck_en && (tx_on ? (tx_left != 8'd0) : (wcnt_inc >= NCR_C));
    assign tx_done   = (state == TX) && i_ck_en && tx_on && (tx_left == 8'd0);

    assign o_rsp_ready = (state == WAIT);
    assign o_busy      = (state != IDLE);

    // Frames are left-aligned in 136 bits; short frames leave don't-care padding below.
    always_comb begin
        tx_frame = '1;
        unique case (i_rsp_kind)
            2'b10:   tx_frame = {2'b00, 6'h3f, i_rsp_long, crc7_120(i_rsp_long), 1'b1};
            2'b11:   tx_frame = {2'b00, 6'h3f, i_rsp_arg, 7'h7f, 1'b1, 88'h0};
            default: tx_frame = {2'b00, i_rsp_index, i_rsp_arg,
                                 crc7_40({2'b00, i_rsp_index, i_rsp_arg}), 1'b1, 88'h0};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (i_ck_en && !i_cmd) state_nxt = RX;
            RX:   if (rx_done) state_nxt = (rx_frame[46] && rx_good) ? WAIT : IDLE;
            WAIT: begin
                if (handshake)   state_nxt = (i_rsp_kind == 2'b00) ? IDLE : TX;
                else if (expire) state_nxt = IDLE;
            end
            TX:   if (tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_sr         <= '0;
            rx_cnt        <= '0;
            wcnt          <= '0;
            tx_sr         <= '1;
            tx_left       <= '0;
            tx_on         <= 1'b0;
            o_cmd_oe      <= 1'b0;
            o_cmd         <= 1'b1;
            o_req_valid   <= 1'b0;
            o_req_index   <= '0;
            o_req_arg     <= '0;
            o_rx_err      <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            o_req_valid   <= 1'b0;
            o_rx_err      <= 1'b0;
            o_rsp_timeout <= 1'b0;

            if (state == IDLE && i_ck_en && !i_cmd) rx_cnt <= '0;
            if (state == RX && i_ck_en) begin
                rx_sr  <= rx_frame[45:0];
                rx_cnt <= rx_cnt + 6'd1;
            end

            // Frames with transmission bit 0 are another card's response: ignore quietly.
            if (rx_done && rx_frame[46]) begin
                if (rx_good) begin
                    o_req_valid <= 1'b1;
                    o_req_index <= rx_frame[45:40];
                    o_req_arg   <= rx_frame[39:8];
                end else begin
                    o_rx_err <= 1'b1;
                end
            end

            if (rx_done) wcnt <= '0;
            else if ((state == WAIT || state == TX) && i_ck_en) wcnt <= wcnt_inc;

            if (expire) o_rsp_timeout <= 1'b1;

            if (handshake && i_rsp_kind != 2'b00) begin
                tx_sr   <= tx_frame;
                tx_left <= (i_rsp_kind == 2'b10) ? 8'd136 : 8'd48;
                tx_on   <= 1'b0;
            end

            if (tx_drive) begin
                o_cmd_oe <= 1'b1;
                o_cmd    <= tx_sr[135];
                tx_sr    <= {tx_sr[134:0], 1'b1};
                tx_left  <= tx_left - 8'd1;
                tx_on    <= 1'b1;
            end

            if (tx_done) begin
                o_cmd_oe <= 1'b0;
                o_cmd    <= 1'b1;
                tx_on    <= 1'b0;
            end
        end
    end
endmodule
